// File: rtl/kmeans_pkg.sv
// Shared constants and the cluster-index type used by the distance,
// store and centroid-update stages of the K-means datapath.
package kmeans_pkg;

    localparam int K_DEF      = 3;
    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 64;
    localparam int IDX_W_DEF  = $clog2(K_DEF);

    typedef logic [IDX_W_DEF-1:0] cluster_idx_t;

endpackage

// File: rtl/kmeans_bank.sv
// One cluster's sample bank: memory, fill counter, full flag and, with
// KMEANS_SUM_EN defined, a running sum of the stored samples.
module kmeans_bank
    import kmeans_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = ADDR_W + 1
`ifdef KMEANS_SUM_EN
    ,parameter int SUM_W = DATA_W + ADDR_W
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full
`ifdef KMEANS_SUM_EN
    ,output logic [SUM_W-1:0] sum
`endif
);

    logic [DATA_W-1:0] mem [DEPTH];

    // The fill pointer is the count itself; the top never asserts wr_en on a full bank.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (wr_en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign full    = (count == CNT_W'(DEPTH));
    assign rd_data = mem[rd_addr];

`ifdef KMEANS_SUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (wr_en) begin
            sum <= sum + SUM_W'(wr_data);
        end
    end
`endif

endmodule

// File: rtl/kmeans_cluster_store.sv
// K-cluster sample store with valid/ready input, registered reads and
// out-of-range index reporting. Define KMEANS_SUM_EN for per-cluster sums.
module kmeans_cluster_store
    import kmeans_pkg::*;
#(
    parameter int K      = K_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int IDX_W  = $clog2(K),
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = ADDR_W + 1
`ifdef KMEANS_SUM_EN
    ,parameter int SUM_W = DATA_W + ADDR_W
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic              clr,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_sel,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  cnt,
    output logic [K-1:0]      full,
    output logic              err
`ifdef KMEANS_SUM_EN
    ,output logic [SUM_W-1:0] sum
`endif
);

    logic [K-1:0]      wr_en;
    logic [DATA_W-1:0] bank_rdata [K];
    logic [CNT_W-1:0]  bank_cnt   [K];
    logic              idx_oob;
    logic              tgt_full;
    logic              xfer;
    logic [DATA_W-1:0] sel_rdata;
    logic [CNT_W-1:0]  sel_cnt;
`ifdef KMEANS_SUM_EN
    logic [SUM_W-1:0]  bank_sum   [K];
    logic [SUM_W-1:0]  sel_sum;
`endif

    for (genvar k = 0; k < K; k++) begin : g_bank
        kmeans_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W)
`ifdef KMEANS_SUM_EN
            ,.SUM_W (SUM_W)
`endif
        ) u_bank (
            .clk     (clk),
            .reset   (reset),
            .clr     (clr),
            .wr_en   (wr_en[k]),
            .wr_data (in_data),
            .rd_addr (rd_addr),
            .rd_data (bank_rdata[k]),
            .count   (bank_cnt[k]),
            .full    (full[k])
`ifdef KMEANS_SUM_EN
            ,.sum    (bank_sum[k])
`endif
        );
    end

    // Out-of-range indices are accepted (and flagged) so a bad index never stalls the producer.
    always_comb begin
        idx_oob   = (int'(in_idx) >= K);
        tgt_full  = 1'b0;
        sel_rdata = '0;
        sel_cnt   = '0;
        wr_en     = '0;
`ifdef KMEANS_SUM_EN
        sel_sum   = '0;
`endif
        for (int k = 0; k < K; k++) begin
            if (int'(in_idx) == k) begin
                tgt_full = full[k];
            end
            if (int'(rd_sel) == k) begin
                sel_rdata = bank_rdata[k];
                sel_cnt   = bank_cnt[k];
`ifdef KMEANS_SUM_EN
                sel_sum   = bank_sum[k];
`endif
            end
        end
        in_ready = !clr && (idx_oob || !tgt_full);
        xfer     = in_valid && in_ready;
        for (int k = 0; k < K; k++) begin
            wr_en[k] = xfer && (int'(in_idx) == k);
        end
    end

    assign cnt = sel_cnt;
`ifdef KMEANS_SUM_EN
    assign sum = sel_sum;
`endif

    // Reads compare against the pre-write count, so a slot being filled this edge reads as 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            err      <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            err      <= xfer && idx_oob;
            if (rd_en) begin
                rd_data <= (CNT_W'(rd_addr) < sel_cnt) ? sel_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_kmeans_cluster_store.sv
// Scoreboard bench for kmeans_cluster_store; sum checks are active when
// KMEANS_SUM_EN is defined for both bench and design.
module tb_kmeans_cluster_store;

    localparam int K      = 3;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 64;
    localparam int IDX_W  = 2;
    localparam int ADDR_W = 6;
    localparam int CNT_W  = 7;
`ifdef KMEANS_SUM_EN
    localparam int SUM_W  = DATA_W + ADDR_W;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [IDX_W-1:0]  in_idx = '0;
    logic              clr = 1'b0;
    logic              rd_en = 1'b0;
    logic [IDX_W-1:0]  rd_sel = '0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  cnt;
    logic [K-1:0]      full;
    logic              err;
`ifdef KMEANS_SUM_EN
    logic [SUM_W-1:0]  sum;
`endif

    int testsRun = 0;
    int failCount = 0;

    int                mcount [K];
    logic [DATA_W-1:0] mmem   [K][DEPTH];
    longint unsigned   msum   [K];
    logic [DATA_W-1:0] sbq    [$];

    kmeans_cluster_store #(
        .K(K), .DATA_W(DATA_W), .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_idx   (in_idx),
        .clr      (clr),
        .rd_en    (rd_en),
        .rd_sel   (rd_sel),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .cnt      (cnt),
        .full     (full),
        .err      (err)
`ifdef KMEANS_SUM_EN
        ,.sum     (sum)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [K-1:0] modelFull();
        logic [K-1:0] f;
        f = '0;
        for (int k = 0; k < K; k++) f[k] = (mcount[k] == DEPTH);
        return f;
    endfunction

    function automatic logic modelReady(input logic c, input logic [IDX_W-1:0] idx);
        if (c) return 1'b0;
        if (int'(idx) >= K) return 1'b1;
        return (mcount[idx] != DEPTH);
    endfunction

    task automatic modelReset();
        for (int k = 0; k < K; k++) begin
            mcount[k] = 0;
            msum[k] = 0;
        end
    endtask

    // Read results are checked here, one cycle after the request was queued.
    always @(negedge clk) begin
        if (reset && rd_valid) begin
            if (sbq.size() == 0) checkOutput("rd_unexpected", 1, 0);
            else checkOutput("rd_data", rd_data, sbq.pop_front());
        end
    end

    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] idx,
                                 input logic c, input logic re, input logic [IDX_W-1:0] sel,
                                 input logic [ADDR_W-1:0] addr);
        logic              expReady;
        logic              xfer;
        logic [DATA_W-1:0] expRd;
        longint unsigned   expCnt;
        in_valid = v;
        in_data  = d;
        in_idx   = idx;
        clr      = c;
        rd_en    = re;
        rd_sel   = sel;
        rd_addr  = addr;
        #1;
        expReady = modelReady(c, idx);
        checkOutput("in_ready", in_ready, expReady);
        xfer = v && expReady;
        if (re) begin
            expRd = '0;
            if (int'(sel) < K && int'(addr) < mcount[sel]) expRd = mmem[sel][addr];
            sbq.push_back(expRd);
        end
        @(posedge clk);
        #1;
        if (c) begin
            modelReset();
        end else if (xfer && int'(idx) < K) begin
            mmem[idx][mcount[idx]] = d;
            mcount[idx]++;
            msum[idx] += d;
        end
        checkOutput("err", err, xfer && int'(idx) >= K);
        checkOutput("rd_valid", rd_valid, re);
        expCnt = (int'(sel) < K) ? longint'(mcount[sel]) : 0;
        checkOutput("cnt", cnt, expCnt);
        checkOutput("full", full, modelFull());
`ifdef KMEANS_SUM_EN
        checkOutput("sum", sum, (int'(sel) < K) ? (msum[sel] & ((64'd1 << SUM_W) - 1)) : 64'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();
        #1;
        checkOutput("rst_cnt", cnt, 0);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_err", err, 0);
`ifdef KMEANS_SUM_EN
        checkOutput("rst_sum", sum, 0);
`endif
        #21;
        reset = 1'b1;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);

        // Three samples into cluster 1, then read slots 0..3 back to back.
        applyStimulus(1, 16'h0011, 1, 0, 0, 1, 0);
        applyStimulus(1, 16'h0022, 1, 0, 0, 1, 0);
        applyStimulus(1, 16'h0033, 1, 0, 0, 1, 0);
        checkOutput("c1_cnt3", cnt, 3);
        for (int a = 0; a < 4; a++) applyStimulus(0, 0, 0, 0, 1, 1, ADDR_W'(a));

        // Fill cluster 0, then offer one more sample.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, DATA_W'(i * 7 + 1), 0, 0, 0, 0, 0);
        checkOutput("c0_full", full[0], 1);
        applyStimulus(1, 16'hdead, 0, 0, 0, 0, 0);
        checkOutput("c0_cnt_depth", cnt, DEPTH);
        applyStimulus(0, 0, 2, 0, 1, 0, ADDR_W'(DEPTH - 1));
        applyStimulus(1, 16'h0044, 2, 0, 0, 2, 0);

        // Out-of-range index: accepted, flagged, nothing stored.
        applyStimulus(1, 16'hbeef, 3, 0, 0, 0, 0);
        checkOutput("oob_err", err, 1);
        for (int s = 0; s < K; s++) applyStimulus(0, 0, 0, 0, 0, IDX_W'(s), 0);
        applyStimulus(0, 0, 0, 0, 0, 3, 0);

        // Clear collides with an offered sample; next write lands at slot 0.
        applyStimulus(1, 16'h0055, 1, 1, 0, 1, 0);
        checkOutput("clr_cnt", cnt, 0);
        applyStimulus(1, 16'h0077, 1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 1);

        // Read the slot being written this same edge, then again afterwards.
        applyStimulus(1, 16'h0099, 2, 0, 1, 2, 0);
        applyStimulus(0, 0, 0, 0, 1, 2, 0);

        // Running sum of cluster 2.
        applyStimulus(0, 0, 0, 1, 0, 2, 0);
        applyStimulus(1, 16'd100, 2, 0, 0, 2, 0);
        applyStimulus(1, 16'd200, 2, 0, 0, 2, 0);
        applyStimulus(1, 16'd300, 2, 0, 0, 2, 0);
`ifdef KMEANS_SUM_EN
        checkOutput("sum600", sum, 600);
`endif
        applyStimulus(0, 0, 0, 1, 0, 2, 0);
`ifdef KMEANS_SUM_EN
        checkOutput("sum_clr", sum, 0);
`endif

        // Random mixed traffic, including bad indices and occasional clears.
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), DATA_W'($urandom), IDX_W'($urandom_range(0, 3)),
                          1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
                          IDX_W'($urandom_range(0, 3)), ADDR_W'($urandom_range(0, 7)));
        end

        // Asynchronous reset in the middle of a cycle with pending outputs.
        applyStimulus(1, 16'h1234, 3, 0, 1, 1, 0);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("arst_cnt", cnt, 0);
        checkOutput("arst_full", full, 0);
        checkOutput("arst_rd_valid", rd_valid, 0);
        checkOutput("arst_rd_data", rd_data, 0);
        checkOutput("arst_err", err, 0);
`ifdef KMEANS_SUM_EN
        checkOutput("arst_sum", sum, 0);
`endif
        sbq.delete();
        modelReset();
        #4;
        reset = 1'b1;
        applyStimulus(1, 16'h4321, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);

        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("sb_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/kmeans_cluster_store.md
# kmeans_cluster_store

Parametrised K-cluster sample store for the K-means datapath. Each incoming sample carries a cluster index assigned by the distance stage. The sample is appended to that cluster's bank at the bank's fill pointer. Per-cluster member counts and stored samples are read back by the centroid-update stage, with an optional running per-cluster sum. It generalises the fixed three-cluster, 16-bit store to K clusters of configurable width and depth, adding a valid/ready handshake, a full flag, a clear, and error reporting.

## Interface
Parameters:
- K, 3, number of clusters (≥2)
- DATA_W, 16, sample width (unsigned)
- DEPTH, 64, samples per cluster bank (power of two)
- IDX_W, $clog2(K), cluster index width
- ADDR_W, $clog2(DEPTH), bank address width
- CNT_W, ADDR_W+1, member-count width
- SUM_W, DATA_W+ADDR_W, sum width (only with KMEANS_SUM_EN)

Ports:
- clk  in  1  clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  sample offered
- in_ready  out  1  sample can be accepted
- in_data  in  DATA_W  sample value
- in_idx  in  IDX_W  target cluster
- clr  in  1  synchronous clear of all counts (new iteration)
- rd_en  in  1  read request
- rd_sel  in  IDX_W  cluster to read / report
- rd_addr  in  ADDR_W  sample slot to read
- rd_valid  out  1  rd_data valid
- rd_data  out  DATA_W  read sample
- cnt  out  CNT_W  member count of cluster rd_sel
- full  out  K  bit k high when count[k]==DEPTH
- err  out  1  one-cycle pulse: in_idx ≥ K on accepted transfer
- sum  out  SUM_W  running sum of cluster rd_sel (KMEANS_SUM_EN only)

## Operation
- Transfer occurs when in_valid && in_ready.
- in_ready = !clr && (in_idx ≥ K || !full[in_idx]). It is combinational on in_idx and clr.
- Transfer with in_idx < K:
  - mem[in_idx][count[in_idx]] ← in_data
  - count[in_idx] increments next edge.
- Transfer with in_idx ≥ K: data discarded, no count change, err pulses high the next cycle.
- A full bank holds off the producer (in_ready low). The store never wraps or overwrites.
- clr: all counts (and sums) become 0 on the next edge. Memory contents are untouched. No transfer is possible while clr is high.
- Read: if rd_en is sampled high, rd_valid=1 on the next cycle, with rd_data as follows:
  - rd_data = mem[rd_sel][rd_addr] if rd_addr < count[rd_sel], else 0.
  - rd_sel ≥ K returns 0.
- Read and write on the same edge: the read uses the pre-write count. A read of the slot being written therefore returns 0.
- cnt and sum are combinational views of registered state selected by rd_sel. cnt=0 for rd_sel ≥ K.
- Reset values: all counts 0, full=0, rd_valid=0, rd_data=0, err=0, sum=0. in_ready=1 after reset when clr=0. Memory is not reset.
- Reset asserted mid-operation clears all counts and pending outputs immediately (asynchronous assertion).

## Timing
- Write: count, full and sum update 1 cycle after the transfer edge.
- Read latency: 1 cycle. Back-to-back reads are sustained every cycle.
- Write throughput: 1 sample/cycle while the target bank is not full.
- err: 1 cycle after the offending transfer.
- clr: its effect is visible on the next cycle. Counts read 0 thereafter.

## Configuration
- KMEANS_SUM_EN defined:
  - Per-cluster unsigned SUM_W accumulators are present. sum[k] += in_data on every valid write to k.
  - The accumulators are cleared by clr and reset.
  - The sum port exists.
- Undefined: no accumulators, no sum port. All other behaviour is identical.

## Structure
- Package kmeans_pkg holds the default K, DATA_W and DEPTH constants, and the cluster-index typedef shared with the distance and centroid stages.
- One sub-module, kmeans_bank, is instantiated K times via generate. It contains:
  - a DEPTH×DATA_W memory
  - the fill counter and full flag
  - the optional accumulator
- The top level holds the index decode, in_ready logic, read mux, err register and output registers.

## Test plan
- Reset, then write 3 samples (0x0011, 0x0022, 0x0033) to cluster 1 → cnt(rd_sel=1)=3. Reads of addr 0..2 return the values 1 cycle later. Addr 3 returns 0.
- Fill cluster 0 with DEPTH writes → full[0]=1, in_ready=0 for in_idx=0, in_ready=1 for in_idx=2. An extra offered sample is not stored; cnt stays DEPTH.
- in_idx=3 with K=3, in_valid=1 → in_ready=1, err pulses 1 cycle, all counts unchanged.
- Counts nonzero, pulse clr alongside in_valid → in_ready=0 that cycle. All cnt=0 next cycle. The following write lands at addr 0.
- Read slot count[2] in the same cycle it is written → rd_data=0. The next read of that slot returns the written value.
- With KMEANS_SUM_EN, write 100, 200, 300 to cluster 2 → sum=600. After clr, sum=0. Assert reset mid-stream → all outputs return to reset values asynchronously.
